lab10_pair_sequencer: RTL

Controller stage directly upstream and downstream of the lab10 datapath (`lab10_top`). It drives the `addr1`/`addr2` read-address pair into the datapath and walks a fixed schedule of 8 address pairs. For each pair it waits a programmable settle latency, then captures the datapath's `result` into an 8-entry result buffer. It also keeps a running sum and the maximum result with its index, and signals completion with a one-cycle `done` pulse.

---
 rtl/lab10_pkg.sv | 18 +
 rtl/lab10_pair_sequencer_if.sv | 29 ++
 rtl/lab10_result_buf.sv | 43 ++++
 rtl/lab10_pair_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/lab10_pkg.sv
// Shared types and default sizing for the lab10 pair sequencer and its result buffer.
// The state enum and the width/count constants live here so every file agrees on them.
package lab10_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NPAIRS = 2 ** ADDR_W;

    // Wide enough for the largest legal settle latency (15).
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lab10_pair_sequencer_if.sv
// Bundle of the sequencer's control, datapath-facing and result-readout signals.
// The master side is the host/datapath environment; the slave side is the sequencer.
interface lab10_pair_sequencer_if #(
    parameter int DATA_W = lab10_pkg::DATA_W,
    parameter int ADDR_W = lab10_pkg::ADDR_W
);
    logic                     start;
    logic [DATA_W-1:0]        result_in;
    logic [ADDR_W-1:0]        addr1;
    logic [ADDR_W-1:0]        addr2;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        rd_idx;
    logic [DATA_W-1:0]        rd_data;
    logic [DATA_W+ADDR_W-1:0] sum;
    logic [DATA_W-1:0]        max_val;
    logic [ADDR_W-1:0]        max_idx;

    modport master (
        output start, result_in, rd_idx,
        input  addr1, addr2, busy, done, rd_data, sum, max_val, max_idx
    );

    modport slave (
        input  start, result_in, rd_idx,
        output addr1, addr2, busy, done, rd_data, sum, max_val, max_idx
    );

endinterface

// File: rtl/lab10_result_buf.sv
// Result register file: one synchronous write port, one combinational read port,
// and every entry cleared asynchronously by rst.
module lab10_result_buf #(
    parameter int DATA_W = lab10_pkg::DATA_W,
    parameter int ADDR_W = lab10_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  wsel;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wsel[gi] = we && (waddr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/lab10_pair_sequencer.sv
// Walks the fixed (k, k+1 mod N) address-pair schedule into the lab10 datapath,
// waits LAT cycles per pair, and captures each result with running sum and maximum.
module lab10_pair_sequencer #(
    parameter int DATA_W = lab10_pkg::DATA_W,
    parameter int ADDR_W = lab10_pkg::ADDR_W,
    parameter int LAT    = 4
) (
    input logic                   clk,
    input logic                   rst,
    lab10_pair_sequencer_if.slave bus
);
    import lab10_pkg::*;

    localparam int                NP       = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAT - 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(NP - 1);

    state_t                   state_reg;
    logic [ADDR_W-1:0]        k_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [ADDR_W-1:0]        addr1_reg;
    logic [ADDR_W-1:0]        addr2_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic [DATA_W+ADDR_W-1:0] sum_reg;
    logic [DATA_W-1:0]        max_val_reg;
    logic [ADDR_W-1:0]        max_idx_reg;

    logic                     capture;
    logic [ADDR_W-1:0]        k_next;
    logic [DATA_W+ADDR_W-1:0] result_ext;

    assign capture    = (state_reg == ST_RUN) && (cnt_reg == CNT_LAST);
    assign k_next     = k_reg + 1'b1;
    assign result_ext = {{ADDR_W{1'b0}}, bus.result_in};

    lab10_result_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (capture),
        .waddr (k_reg),
        .wdata (bus.result_in),
        .raddr (bus.rd_idx),
        .rdata (bus.rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            k_reg       <= '0;
            cnt_reg     <= '0;
            addr1_reg   <= '0;
            addr2_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            sum_reg     <= '0;
            max_val_reg <= '0;
            max_idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg   <= ST_RUN;
                        k_reg       <= '0;
                        cnt_reg     <= '0;
                        addr1_reg   <= '0;
                        addr2_reg   <= ADDR_W'(1);
                        busy_reg    <= 1'b1;
                        sum_reg     <= '0;
                        max_val_reg <= '0;
                        max_idx_reg <= '0;
                    end
                end

                ST_RUN: begin
                    if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        sum_reg <= sum_reg + result_ext;
                        // Strict compare keeps the earliest index on a tie.
                        if (bus.result_in > max_val_reg) begin
                            max_val_reg <= bus.result_in;
                            max_idx_reg <= k_reg;
                        end
                        if (k_reg != K_LAST) begin
                            k_reg     <= k_next;
                            addr1_reg <= k_next;
                            addr2_reg <= k_next + 1'b1;
                            cnt_reg   <= '0;
                        end else begin
                            // Addresses stay on the final (last, 0) pair.
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr1   = addr1_reg;
    assign bus.addr2   = addr2_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.sum     = sum_reg;
    assign bus.max_val = max_val_reg;
    assign bus.max_idx = max_idx_reg;

endmodule
